uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter BAUD_DIV, default 434, meaning clk cycles per bit period (legal range 4..65535).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL provide port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL provide port rx_finish  input  1  one-cycle consumer acknowledge of the held byte or error.
REQ-006 SHALL provide port rx_data  output  8  last received byte, LSB first on the line.
REQ-007 SHALL provide port irq  output  1  level, byte valid in rx_data.
REQ-008 SHALL provide port busy  output  1  frame reception or error hold in progress.
REQ-009 SHALL provide port frame_err  output  1  level, last frame had stop-bit (or parity) error.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (flops reset to 1); all decoding uses the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (only with macro), STOP, ERR.
REQ-012 IDLE: synchronized rx falling to 0 -> START, bit counter cleared, busy=1 from the next cycle.
REQ-013 START: sample at BAUD_DIV/2 (integer floor) cycles; sample 1 -> IDLE (false start, busy drops, no flags); sample 0 -> DATA.
REQ-014 DATA: sample every BAUD_DIV cycles after the start mid-point; 8 samples shifted LSB first; after the 8th -> STOP (or PARITY).
REQ-015 STOP: sample 1 -> rx_data loaded with the shifted byte, irq=1 and busy=0 on the cycle after the sample, -> IDLE.
REQ-016 STOP: sample 0 -> ERR; frame_err=1 and busy=1 from the cycle after the sample; rx_data and irq unchanged.
REQ-017 ERR: remain until rx_finish=1 and synchronized rx=1 in the same cycle; then frame_err=0, busy=0, -> IDLE.
REQ-018 irq SHALL stay 1 until rx_finish=1 observed in IDLE/START/DATA/STOP; cleared the following cycle.
REQ-019 A new frame MAY begin while irq=1 (busy=1, irq held) so the consumer detects overrun; a second valid stop overwrites rx_data, irq stays 1.
REQ-020 rx_finish coincident with a valid stop-bit completion: set wins, irq remains 1.
REQ-021 rx_finish with irq=0 and not in ERR SHALL have no effect.
REQ-022 Baud counter SHALL be 16 bits, wrap to 0 at BAUD_DIV-1 and never overflow.

Reset
REQ-023 rst_n=0 at a clk edge SHALL force IDLE, counters 0, rx_data=8'h00, irq=0, busy=0, frame_err=0, synchronizer=1, regardless of state (mid-frame reset discards the partial byte).
REQ-024 After rst_n release, no frame SHALL be accepted until rx has been sampled high at least once.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: PARITY state after DATA samples one even-parity bit; mismatch -> ERR identically to a stop-bit error, stop bit not sampled.
REQ-026 Macro undefined: no PARITY state, frame is 1 start + 8 data + 1 stop.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state encoding, DATA_BITS=8 and the default BAUD_DIV constant.
REQ-028 Sub-module uart_baud_tick SHALL generate the mid-bit and full-bit sample strobes from BAUD_DIV; synchronizer and FSM stay in uart_rx.

Verification (BAUD_DIV=8)
REQ-029 Frame 0xA5, good stop -> rx_data=8'hA5, irq=1 one cycle after stop sample, busy=0; rx_finish pulse -> irq=0 next cycle.
REQ-030 rx low for 2 cycles then high -> busy pulses, returns 0 by the START mid-sample, irq=0, frame_err=0.
REQ-031 Frame 0x3C with stop=0 -> frame_err=1, busy=1, rx_data unchanged; rx_finish with rx high -> both 0 next cycle.
REQ-032 Frames 0x11 then 0x22 with no rx_finish -> busy=1 during second while irq=1; rx_data=8'h22, irq stays 1.
REQ-033 rst_n=0 mid-DATA of 0xFF -> all outputs reset; following frame 0x5A received correctly.
REQ-034 With UART_RX_PARITY_EN: 0x07 with parity 1 -> irq=1, rx_data=8'h07; parity 0 -> frame_err=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver constants and FSM state encoding (PARITY state only when UART_RX_PARITY_EN is defined)
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int BAUD_DIV_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16-bit baud counter giving mid-bit and full-bit sample strobes
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic half,
    output logic mid_tick,
    output logic full_tick
);

    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

    logic [15:0] cnt;
    logic        wrap;

    assign mid_tick  = cnt == HALF_M1;
    assign full_tick = cnt == FULL_M1;
    assign wrap      = half ? mid_tick : full_tick;

    always_ff @(posedge clk) begin
        if (!rst_n || clear || wrap)
            cnt <= 16'd0;
        else
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with held byte, level irq and frame error hold
// Optional even parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_finish,
    output logic [7:0] rx_data,
    output logic       irq,
    output logic       busy,
    output logic       frame_err
);

    logic       s1, rx_s, armed;
    logic [1:0] live;
    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n, rx_data_n;
    logic       irq_n, err_n;
    logic       mid_tick, full_tick, tick_clear, tick_half;

    assign tick_clear = state == IDLE || state == ERR;
    assign tick_half  = state == START;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tick_clear),
        .half      (tick_half),
        .mid_tick  (mid_tick),
        .full_tick (full_tick)
    );

    // live[1] marks rx_s as holding a real line sample rather than its reset value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= 1'b1;
            rx_s      <= 1'b1;
            live      <= 2'b00;
            armed     <= 1'b0;
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            irq       <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            s1        <= rx;
            rx_s      <= s1;
            live      <= {live[0], 1'b1};
            armed     <= armed | (live[1] & rx_s);
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            rx_data   <= rx_data_n;
            irq       <= irq_n;
            busy      <= state_n != IDLE;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        rx_data_n = rx_data;
        irq_n     = irq & ~(rx_finish & (state != ERR));
        err_n     = frame_err;
        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_n   = START;
                    bit_cnt_n = 3'd0;
                end
            end
            START: begin
                if (mid_tick)
                    state_n = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (full_tick) begin
                    shift_n   = {rx_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == 3'(DATA_BITS - 1))
                        state_n = PARITY;
`else
                    if (bit_cnt == 3'(DATA_BITS - 1))
                        state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_tick) begin
                    state_n = (rx_s == ^shift) ? STOP : ERR;
                    err_n   = rx_s != ^shift;
                end
            end
`endif
            STOP: begin
                if (full_tick) begin
                    state_n   = rx_s ? IDLE : ERR;
                    rx_data_n = rx_s ? shift : rx_data;
                    irq_n     = rx_s | irq_n;
                    err_n     = ~rx_s;
                end
            end
            ERR: begin
                if (rx_finish && rx_s) begin
                    state_n = IDLE;
                    err_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed checks of uart_rx at BAUD_DIV=8 against a frame-level model
module tb_uart_rx;

    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_finish = 1'b0;
    logic [7:0] rx_data;
    logic       irq, busy, frame_err;

    int passed = 0;
    int total  = 0;

    // frame-level model of the consumer-visible outputs
    logic [7:0] m_data = 8'h00;
    logic       m_irq  = 1'b0;
    logic       m_err  = 1'b0;

    logic obs_busy_data, obs_irq_data, obs_busy_stop, obs_irq_stop, obs_busy_end, obs_irq_end;

    uart_rx #(.BAUD_DIV(BD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_finish (rx_finish),
        .rx_data   (rx_data),
        .irq       (irq),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic par_ok);
        if (!par_ok || !stop) begin
            m_err = 1'b1;
        end else begin
            m_data = b;
            m_irq  = 1'b1;
        end
    endtask

    // drives one frame starting at a negedge; fin_k >= 0 pulses rx_finish at that stop-bit cycle
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok, input int fin_k);
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) @(negedge clk);
            if (i == 4) begin
                obs_busy_data = busy;
                obs_irq_data  = irq;
            end
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ ~par_ok;
        repeat (BD) @(negedge clk);
`endif
        rx = stop;
        for (int k = 0; k < BD; k++) begin
            if (fin_k >= 0)
                rx_finish = (k == fin_k);
            if (k == 4) begin
                obs_busy_stop = busy;
                obs_irq_stop  = irq;
            end
            @(negedge clk);
        end
        rx_finish    = 1'b0;
        rx           = 1'b1;
        obs_busy_end = busy;
        obs_irq_end  = irq;
    endtask

    task automatic pulse_finish();
        rx_finish = 1'b1;
        @(negedge clk);
        rx_finish = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_err: got %b want 0", frame_err); else passed++;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL low_after_reset_busy: got %b want 0", busy); else passed++;
        idle(20);
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        model_frame(8'hA5, 1'b1, 1'b1);
        total++; if (obs_irq_stop !== 1'b0) $display("FAIL good_irq_early: got %b want 0", obs_irq_stop); else passed++;
        total++; if (obs_busy_stop !== 1'b1) $display("FAIL good_busy_mid: got %b want 1", obs_busy_stop); else passed++;
        total++; if (obs_irq_end !== m_irq) $display("FAIL good_irq: got %b want %b", obs_irq_end, m_irq); else passed++;
        total++; if (obs_busy_end !== 1'b0) $display("FAIL good_busy_end: got %b want 0", obs_busy_end); else passed++;
        total++; if (rx_data !== m_data) $display("FAIL good_data: got %h want %h", rx_data, m_data); else passed++;
        idle(4);
        pulse_finish();
        m_irq = 1'b0;
        total++; if (irq !== m_irq) $display("FAIL good_irq_clear: got %b want %b", irq, m_irq); else passed++;
    endtask

    task automatic test_false_start();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL false_busy_pulse: got %b want 1", busy); else passed++;
        repeat (6) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL false_busy_drop: got %b want 0", busy); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL false_irq: got %b want 0", irq); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL false_err: got %b want 0", frame_err); else passed++;
        idle(20);
    endtask

    task automatic test_finish_idle();
        pulse_finish();
        idle(2);
        total++; if (rx_data !== m_data) $display("FAIL idle_fin_data: got %h want %h", rx_data, m_data); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL idle_fin_irq: got %b want 0", irq); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL idle_fin_err: got %b want 0", frame_err); else passed++;
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        model_frame(8'h3C, 1'b0, 1'b1);
        total++; if (frame_err !== m_err) $display("FAIL ferr_flag: got %b want %b", frame_err, m_err); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL ferr_busy: got %b want 1", busy); else passed++;
        total++; if (rx_data !== m_data) $display("FAIL ferr_data: got %h want %h", rx_data, m_data); else passed++;
        total++; if (irq !== m_irq) $display("FAIL ferr_irq: got %b want %b", irq, m_irq); else passed++;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        pulse_finish();
        total++; if (frame_err !== 1'b1) $display("FAIL ferr_hold_low: got %b want 1", frame_err); else passed++;
        idle(5);
        pulse_finish();
        m_err = 1'b0;
        total++; if (frame_err !== m_err) $display("FAIL ferr_clear: got %b want %b", frame_err, m_err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL ferr_busy_clear: got %b want 0", busy); else passed++;
        idle(10);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 1'b1, -1);
        model_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1, -1);
        model_frame(8'h22, 1'b1, 1'b1);
        total++; if (obs_busy_data !== 1'b1) $display("FAIL ovr_busy: got %b want 1", obs_busy_data); else passed++;
        total++; if (obs_irq_data !== 1'b1) $display("FAIL ovr_irq_mid: got %b want 1", obs_irq_data); else passed++;
        total++; if (rx_data !== m_data) $display("FAIL ovr_data: got %h want %h", rx_data, m_data); else passed++;
        total++; if (irq !== m_irq) $display("FAIL ovr_irq: got %b want %b", irq, m_irq); else passed++;
        idle(10);
    endtask

    task automatic test_finish_coincident();
        send_frame(8'h6B, 1'b1, 1'b1, 6);
        model_frame(8'h6B, 1'b1, 1'b1);
        total++; if (irq !== m_irq) $display("FAIL coinc_irq: got %b want %b", irq, m_irq); else passed++;
        total++; if (rx_data !== m_data) $display("FAIL coinc_data: got %h want %h", rx_data, m_data); else passed++;
        pulse_finish();
        m_irq = 1'b0;
        total++; if (irq !== m_irq) $display("FAIL coinc_clear: got %b want %b", irq, m_irq); else passed++;
        idle(10);
    endtask

    task automatic test_reset_mid();
        logic [7:0] ff = 8'hFF;
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = ff[i];
            repeat (BD) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_data = 8'h00; m_irq = 1'b0; m_err = 1'b0;
        total++; if (rx_data !== m_data) $display("FAIL mid_rst_data: got %h want %h", rx_data, m_data); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL mid_rst_irq: got %b want 0", irq); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", frame_err); else passed++;
        idle(3 * BD);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        model_frame(8'h5A, 1'b1, 1'b1);
        total++; if (rx_data !== m_data) $display("FAIL post_rst_data: got %h want %h", rx_data, m_data); else passed++;
        total++; if (irq !== m_irq) $display("FAIL post_rst_irq: got %b want %b", irq, m_irq); else passed++;
        pulse_finish();
        m_irq = 1'b0;
        idle(10);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1, -1);
        model_frame(8'h07, 1'b1, 1'b1);
        total++; if (irq !== m_irq) $display("FAIL par_ok_irq: got %b want %b", irq, m_irq); else passed++;
        total++; if (rx_data !== 8'h07) $display("FAIL par_ok_data: got %h want 07", rx_data); else passed++;
        pulse_finish();
        m_irq = 1'b0;
        idle(10);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        model_frame(8'h07, 1'b1, 1'b0);
        total++; if (frame_err !== m_err) $display("FAIL par_bad_err: got %b want %b", frame_err, m_err); else passed++;
        total++; if (irq !== m_irq) $display("FAIL par_bad_irq: got %b want %b", irq, m_irq); else passed++;
        idle(3);
        pulse_finish();
        m_err = 1'b0;
        idle(10);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [7:0] b;
            logic       stop, par_ok;
            b    = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
`ifdef UART_RX_PARITY_EN
            par_ok = $urandom_range(0, 3) != 0;
`else
            par_ok = 1'b1;
`endif
            send_frame(b, stop, par_ok, -1);
            model_frame(b, stop, par_ok);
            total++; if (rx_data !== m_data) $display("FAIL rnd_data[%0d]: got %h want %h", n, rx_data, m_data); else passed++;
            total++; if (irq !== m_irq) $display("FAIL rnd_irq[%0d]: got %b want %b", n, irq, m_irq); else passed++;
            total++; if (frame_err !== m_err) $display("FAIL rnd_err[%0d]: got %b want %b", n, frame_err, m_err); else passed++;
            total++; if (busy !== m_err) $display("FAIL rnd_busy[%0d]: got %b want %b", n, busy, m_err); else passed++;
            idle(3);
            if (m_err) begin
                pulse_finish();
                m_err = 1'b0;
                total++; if (frame_err !== m_err) $display("FAIL rnd_recover[%0d]: got %b want %b", n, frame_err, m_err); else passed++;
            end else if ($urandom_range(0, 1) == 1) begin
                pulse_finish();
                m_irq = 1'b0;
                total++; if (irq !== m_irq) $display("FAIL rnd_ack[%0d]: got %b want %b", n, irq, m_irq); else passed++;
            end
            idle($urandom_range(0, 12));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_false_start();
        test_finish_idle();
        test_frame_err();
        test_back_to_back();
        test_finish_coincident();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
